// File: rtl/det_matrix_loader.sv
// det_matrix_loader: streams an NxN matrix (N=2..5) into a 5x5 identity-padded
// buffer for a combinational determinant unit, waits for it to settle, then
// returns the captured 8-bit determinant over a valid/ready handshake.
module det_matrix_loader #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           tamanho,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic [25*DATA_W-1:0] mat_flat,
  input  logic [DATA_W-1:0]    det_in,
  output logic                 res_valid,
  output logic [DATA_W-1:0]    res_data,
  input  logic                 res_ready,
  output logic                 busy,
  output logic                 erro
);

  localparam int unsigned DIM    = 5;
  localparam int unsigned NELEM  = DIM * DIM;
  localparam int unsigned MAT_W  = NELEM * DATA_W;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // 5x5 identity in the flat row-major layout seen by the determinant unit
  function automatic logic [MAT_W-1:0] identity_mat();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int unsigned d = 0; d < DIM; d++) begin
      m[DATA_W*(d*DIM+d) +: DATA_W] = DATA_W'(1);
    end
    return m;
  endfunction

  localparam logic [MAT_W-1:0] IDENTITY = identity_mat();

  state_t             r_state;
  logic [CNT_W-1:0]   r_n;
  logic [CNT_W-1:0]   r_row;
  logic [CNT_W-1:0]   r_col;
  logic [WAIT_W-1:0]  r_wait;
  logic [MAT_W-1:0]   r_mat;
  logic [DATA_W-1:0]  r_res_data;
  logic               r_res_valid;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_erro;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_n_nxt;
  logic [CNT_W-1:0]   w_row_nxt;
  logic [CNT_W-1:0]   w_col_nxt;
  logic [WAIT_W-1:0]  w_wait_nxt;
  logic [MAT_W-1:0]   w_mat_nxt;
  logic [DATA_W-1:0]  w_res_nxt;
  logic               w_erro_nxt;
  logic               w_size_ok;
  logic               w_accept;
  logic               w_last_col;
  logic               w_last_row;
  logic               w_wait_done;
  logic [IDX_W-1:0]   w_wr_idx;

  assign in_ready  = r_in_ready;
  assign mat_flat  = r_mat;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign busy      = r_busy;
  assign erro      = r_erro;

  // Handshake and position decode for the load stream
  assign w_size_ok   = (tamanho >= 3'd2) && (tamanho <= 3'd5);
  assign w_accept    = r_in_ready && in_valid;
  assign w_last_col  = (r_col == (r_n - 3'd1));
  assign w_last_row  = (r_row == (r_n - 3'd1));
  assign w_wait_done = (r_wait == WAIT_W'(WAIT_CYC - 1));
  assign w_wr_idx    = IDX_W'(r_row) * IDX_W'(DIM) + IDX_W'(r_col);

  // Next-state and datapath update for IDLE/LOAD/WAIT/DONE
  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_wait_nxt  = r_wait;
    w_mat_nxt   = r_mat;
    w_res_nxt   = r_res_data;
    w_erro_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_size_ok) begin
            w_state_nxt = S_LOAD;
            w_n_nxt     = tamanho;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
            w_mat_nxt   = IDENTITY;
          end else begin
            w_erro_nxt  = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (w_accept) begin
          for (int unsigned e = 0; e < NELEM; e++) begin
            if (w_wr_idx == IDX_W'(e)) begin
              w_mat_nxt[DATA_W*e +: DATA_W] = in_data;
            end
          end
          if (w_last_col) begin
            w_col_nxt = '0;
            if (w_last_row) begin
              // N*N-th beat: buffer is complete, let the determinant settle
              w_row_nxt   = '0;
              w_wait_nxt  = '0;
              w_state_nxt = S_WAIT;
            end else begin
              w_row_nxt = r_row + 3'd1;
            end
          end else begin
            w_col_nxt = r_col + 3'd1;
          end
        end
      end

      S_WAIT: begin
        if (w_wait_done) begin
          w_res_nxt   = det_in;
          w_wait_nxt  = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_wait_nxt  = r_wait + WAIT_W'(1);
        end
      end

      S_DONE: begin
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_wait      <= '0;
      r_mat       <= IDENTITY;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_erro      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_n         <= w_n_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_wait      <= w_wait_nxt;
      r_mat       <= w_mat_nxt;
      r_res_data  <= w_res_nxt;
      r_res_valid <= (w_state_nxt == S_DONE);
      r_in_ready  <= (w_state_nxt == S_LOAD);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_erro      <= w_erro_nxt;
    end
  end

endmodule

// File: tb/tb_det_matrix_loader.sv
// Self-checking bench for det_matrix_loader: table vectors, error/reset
// sequences and randomized transactions against a permutation-sum determinant.
module tb_det_matrix_loader;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned WAIT_CYC = 2;
  localparam int unsigned MAT_W    = 25 * DATA_W;

  typedef logic [7:0] elem_arr_t [25];

  typedef struct {
    int        n;
    elem_arr_t a;
    logic [7:0] exp;
    int        stall;
    int        hold;
    bit        noise;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [2:0]        tamanho;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [MAT_W-1:0]  mat_flat;
  logic [7:0]        det_in;
  logic              res_valid;
  logic [7:0]        res_data;
  logic              res_ready;
  logic              busy;
  logic              erro;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  det_matrix_loader #(.DATA_W(DATA_W), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .tamanho(tamanho),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mat_flat(mat_flat), .det_in(det_in), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready), .busy(busy), .erro(erro)
  );

  // Leibniz sum over all permutations, wrapping modulo 2^32 (low byte is exact)
  function automatic logic [7:0] det_mod(input int n, input elem_arr_t a);
    int unsigned acc;
    int unsigned prod;
    int          total;
    int          t;
    int          inv;
    int          p [5];
    bit          ok;
    acc   = 0;
    total = 1;
    for (int i = 0; i < n; i++) total = total * n;
    for (int idx = 0; idx < total; idx++) begin
      t  = idx;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
        p[i] = t % n;
        t    = t / n;
      end
      for (int i = 0; i < n; i++)
        for (int j = 0; j < i; j++)
          if (p[i] == p[j]) ok = 1'b0;
      if (ok) begin
        inv  = 0;
        prod = 1;
        for (int i = 0; i < n; i++) begin
          for (int j = i + 1; j < n; j++)
            if (p[i] > p[j]) inv++;
          prod = prod * 32'(a[i*n + p[i]]);
        end
        if (inv % 2 == 1) acc = acc - prod;
        else              acc = acc + prod;
      end
    end
    return acc[7:0];
  endfunction

  function automatic logic [MAT_W-1:0] ident();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int d = 0; d < 5; d++) m[8*(6*d) +: 8] = 8'd1;
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] exp_buf(input int n, input elem_arr_t a);
    logic [MAT_W-1:0] m;
    m = ident();
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        m[8*(5*r + c) +: 8] = a[r*n + c];
    return m;
  endfunction

  // Stand-in for the combinational 5x5 determinant unit
  elem_arr_t buf5;
  always_comb begin
    for (int e = 0; e < 25; e++) buf5[e] = mat_flat[8*e +: 8];
    det_in = det_mod(5, buf5);
  end

  task automatic chk(input string nm, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic [MAT_W-1:0] eb;
    int k;
    int cyc;
    int lat;
    eb = exp_buf(v.n, v.a);
    @(negedge clk);
    start   = 1'b1;
    tamanho = 3'(v.n);
    @(negedge clk);
    start = 1'b0;
    chk("busy_load", MAT_W'(busy), MAT_W'(1));
    chk("mat_reinit", mat_flat, ident());
    k   = 0;
    cyc = 0;
    while (k < v.n * v.n && cyc < 500) begin
      chk("in_ready_load", MAT_W'(in_ready), MAT_W'(1));
      case (v.stall)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 1);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? v.a[k] : 8'($urandom);
      if (v.noise) begin
        start   = 1'($urandom_range(0, 1));
        tamanho = 3'($urandom);
      end
      @(negedge clk);
      if (in_valid) k++;
      cyc++;
    end
    chk("beat_count", MAT_W'(k), MAT_W'(v.n * v.n));
    in_valid = 1'b0;
    chk("in_ready_drop", MAT_W'(in_ready), MAT_W'(0));
    lat = 0;
    while (!res_valid && lat < 50) begin
      if (v.noise) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        start    = 1'b1;
        tamanho  = 3'($urandom_range(2, 5));
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", MAT_W'(lat), MAT_W'(WAIT_CYC));
    chk("res_data", MAT_W'(res_data), MAT_W'(v.exp));
    chk("mat_final", mat_flat, eb);
    for (int h = 0; h < v.hold; h++) begin
      res_ready = 1'b0;
      @(negedge clk);
      chk("hold_valid", MAT_W'(res_valid), MAT_W'(1));
      chk("hold_data", MAT_W'(res_data), MAT_W'(v.exp));
      chk("hold_mat", mat_flat, eb);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    chk("idle_busy", MAT_W'(busy), MAT_W'(0));
    chk("valid_fall", MAT_W'(res_valid), MAT_W'(0));
    chk("res_keep", MAT_W'(res_data), MAT_W'(v.exp));
    @(negedge clk);
    chk("no_restart", MAT_W'(busy), MAT_W'(0));
  endtask

  task automatic bad_size(input int sz);
    logic [MAT_W-1:0] snap;
    snap = mat_flat;
    @(negedge clk);
    start   = 1'b1;
    tamanho = 3'(sz);
    @(negedge clk);
    start = 1'b0;
    chk("erro_pulse", MAT_W'(erro), MAT_W'(1));
    chk("erro_busy", MAT_W'(busy), MAT_W'(0));
    chk("erro_ready", MAT_W'(in_ready), MAT_W'(0));
    chk("erro_mat", mat_flat, snap);
    @(negedge clk);
    chk("erro_clear", MAT_W'(erro), MAT_W'(0));
    chk("erro_idle", MAT_W'(busy), MAT_W'(0));
  endtask

  vec_t tbl [4];
  vec_t rv;
  int   bad_sizes [4];

  initial begin
    // directed vectors
    for (int i = 0; i < 4; i++) begin
      for (int e = 0; e < 25; e++) tbl[i].a[e] = 8'd0;
      tbl[i].stall = 0;
      tbl[i].hold  = 0;
      tbl[i].noise = 1'b0;
    end
    tbl[0].n = 2; tbl[0].a[0] = 8'd3; tbl[0].a[1] = 8'd1; tbl[0].a[2] = 8'd2; tbl[0].a[3] = 8'd4;
    tbl[0].exp = 8'd10;
    tbl[1].n = 3; tbl[1].a[0] = 8'd2; tbl[1].a[4] = 8'd3; tbl[1].a[8] = 8'd4;
    tbl[1].exp = 8'd24; tbl[1].stall = 1; tbl[1].hold = 10;
    tbl[2].n = 5; tbl[2].exp = 8'd0; tbl[2].noise = 1'b1; tbl[2].hold = 3;
    tbl[3].n = 5; tbl[3].exp = 8'd32;
    for (int d = 0; d < 5; d++) begin
      tbl[2].a[6*d] = 8'd4;
      tbl[3].a[6*d] = 8'd2;
    end
    bad_sizes[0] = 6; bad_sizes[1] = 1; bad_sizes[2] = 0; bad_sizes[3] = 7;

    reset = 1'b1; start = 1'b0; tamanho = 3'd0; in_valid = 1'b0;
    in_data = 8'd0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", MAT_W'(in_ready), MAT_W'(0));
    chk("rst_res_valid", MAT_W'(res_valid), MAT_W'(0));
    chk("rst_res_data", MAT_W'(res_data), MAT_W'(0));
    chk("rst_busy", MAT_W'(busy), MAT_W'(0));
    chk("rst_erro", MAT_W'(erro), MAT_W'(0));
    chk("rst_mat", mat_flat, ident());
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_txn(tbl[i]);
    for (int i = 0; i < 4; i++) bad_size(bad_sizes[i]);

    // reset in the middle of an N=5 load
    @(negedge clk);
    start = 1'b1; tamanho = 3'd5;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 7; b++) begin
      in_valid = 1'b1;
      in_data  = 8'(b + 9);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", MAT_W'(busy), MAT_W'(0));
    chk("mid_rst_ready", MAT_W'(in_ready), MAT_W'(0));
    chk("mid_rst_mat", mat_flat, ident());
    chk("mid_rst_valid", MAT_W'(res_valid), MAT_W'(0));
    chk("mid_rst_data", MAT_W'(res_data), MAT_W'(0));

    // randomized transactions
    for (int t = 0; t < 25; t++) begin
      rv.n = (t == 0) ? 5 : int'($urandom_range(2, 5));
      for (int e = 0; e < 25; e++) rv.a[e] = 8'd0;
      for (int e = 0; e < rv.n * rv.n; e++) rv.a[e] = 8'($urandom);
      rv.exp   = det_mod(rv.n, rv.a);
      rv.stall = int'($urandom_range(0, 2));
      rv.hold  = int'($urandom_range(0, 4));
      rv.noise = 1'($urandom_range(0, 1));
      run_txn(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/det_matrix_loader.md
Name: det_matrix_loader

Overview:
- Upstream feeder for the combinational 5x5 determinant unit.
- Accepts an NxN matrix (N = 2..5) as a serial byte stream over a valid/ready handshake, row-major.
- Embeds the matrix top-left in a 5x5 buffer padded with identity, so the 5x5 determinant equals det(A). Drives the buffer to the determinant unit, waits a settle interval, captures the 8-bit result and returns it over a valid/ready handshake.

Parameters:
- DATA_W, 8, element and result width.
- WAIT_CYC, 2, cycles allowed for the combinational determinant path to settle before capture; must be at least 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a new load; sampled only in IDLE.
- tamanho  input  3  matrix order N; valid range 2..5; sampled with start.
- in_valid  input  1  element beat valid.
- in_data  input  DATA_W  element value, row-major.
- in_ready  output  1  loader accepts an element this cycle.
- mat_flat  output  25*DATA_W  5x5 buffer to the determinant unit. Element (r,c), 0-based, occupies bits [DATA_W*(5r+c) +: DATA_W].
- det_in  input  DATA_W  determinant returned by the determinant unit.
- res_valid  output  1  res_data holds a captured determinant.
- res_data  output  DATA_W  captured determinant, modulo 2^DATA_W.
- res_ready  input  1  consumer accepts the result.
- busy  output  1  high in any state except IDLE.
- erro  output  1  one-cycle pulse when start arrives with tamanho outside 2..5.

Behaviour:
- Reset values:
  - State IDLE.
  - in_ready=0, res_valid=0, res_data=0, busy=0, erro=0.
  - mat_flat = 5x5 identity: diagonal 1, all other elements 0.
  - Row, column and wait counters = 0.
- Reset applied in any state, including mid-LOAD or mid-WAIT, returns to the full reset condition on the next edge. Partially loaded data is discarded.
- FSM states: IDLE, LOAD, WAIT, DONE.
- IDLE:
  - start=1 with tamanho in 2..5: latch N, reinitialise mat_flat to identity, clear row/col, go to LOAD.
  - start=1 with tamanho in {0,1,6,7}: erro=1 for exactly that next cycle, stay in IDLE, mat_flat unchanged.
- LOAD:
  - in_ready=1.
  - Each beat with in_valid & in_ready writes in_data to (row,col).
  - col increments; at col=N-1 it wraps to 0 and row increments.
  - Elements outside the NxN top-left block keep their identity values.
  - in_valid low stalls without penalty.
  - The beat that writes (N-1,N-1), the N*N-th beat, moves the FSM to WAIT on the same edge; in_ready drops the following cycle.
- WAIT:
  - in_ready=0; mat_flat is stable.
  - Stays exactly WAIT_CYC cycles.
  - On the edge ending the last WAIT cycle, det_in is registered into res_data and the FSM moves to DONE.
- DONE:
  - res_valid=1; res_data and mat_flat are held stable.
  - On a cycle with res_ready=1, the FSM returns to IDLE at the next edge and res_valid falls.
  - res_data keeps its last value until the next capture.
- Latency: with the last beat accepted at edge E, res_valid is first high in the cycle after edge E+WAIT_CYC.
- start is ignored outside IDLE. in_valid is ignored outside LOAD. res_ready is ignored outside DONE.
- In DONE, start and res_ready high together: only the result is consumed. The new start must be presented again in IDLE.
- Arithmetic: no arithmetic in this block. res_data is det_in verbatim, an 8-bit wrap-around value.
- busy = (state != IDLE).

Test Plan:
- N=2, stream 3,1,2,4 with no stalls, WAIT_CYC=2, real determinant unit attached. Required: in_ready high for exactly 4 accepted beats; res_valid high 3 cycles after the last beat edge; res_data=10; mat_flat diagonals (2,2),(3,3),(4,4)=1.
- N=3, diag(2,3,4), in_valid toggling every other cycle, res_ready held low 10 cycles. Required: res_data=24; res_valid and res_data stable for all 10 cycles; IDLE one edge after res_ready=1.
- N=5, diag(4,4,4,4,4). Required: res_data=0 (1024 mod 256). Repeat with diag(2,...) and require res_data=32.
- start with tamanho=6. Required: erro high exactly 1 cycle, busy stays 0, in_ready stays 0, mat_flat unchanged. Then tamanho=1 gives the same response.
- Reset asserted after 7 of 25 beats for N=5. Required next cycle: IDLE, in_ready=0, busy=0, mat_flat=identity. A subsequent full load then completes correctly.
- start pulsed during LOAD and WAIT, extra in_valid beats during WAIT and DONE. Required: no state change, no buffer writes, captured result unaffected.
